key_pulse_gen: RTL

Debounces one raw active-low pushbutton and converts it into clean single-cycle step pulses for the counter stage. It runs on the board clock, and its `press_pulse` acts as the counter's count-enable. Optional auto-repeat issues further pulses while the key is held. It sits directly upstream of the mod-8 counter / seven-segment path.

---
 rtl/key_pulse_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/key_pulse_gen.sv
// Debounces an active-low pushbutton into single-cycle press/release pulses.
// Define KEY_PULSE_AUTOREPEAT_EN to add auto-repeat press pulses while the key is held.
module key_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_active
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("key_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    state_t            state_reg, state_next;
    logic              sync1_reg, ks_reg;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic              press_pulse_reg, press_pulse_next;
    logic              release_pulse_reg, release_pulse_next;

`ifdef KEY_PULSE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
    logic              repeat_active_reg, repeat_active_next;
`endif

    // key_n is asynchronous to clkin; both stages idle at "released".
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            ks_reg    <= 1'b1;
        end else begin
            sync1_reg <= key_n;
            ks_reg    <= sync1_reg;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            db_cnt_reg        <= '0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
`ifdef KEY_PULSE_AUTOREPEAT_EN
            rep_cnt_reg       <= '0;
            repeat_active_reg <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            db_cnt_reg        <= db_cnt_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
`ifdef KEY_PULSE_AUTOREPEAT_EN
            rep_cnt_reg       <= rep_cnt_next;
            repeat_active_reg <= repeat_active_next;
`endif
        end
    end

    always_comb begin
        state_next         = state_reg;
        db_cnt_next        = db_cnt_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
`ifdef KEY_PULSE_AUTOREPEAT_EN
        rep_cnt_next       = rep_cnt_reg;
        repeat_active_next = repeat_active_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!ks_reg) begin
                    state_next  = PRESS_CHK;
                    db_cnt_next = '0;
                end
            end
            PRESS_CHK: begin
                if (ks_reg) begin
                    state_next = IDLE;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next       = HELD;
                    press_pulse_next = 1'b1;
`ifdef KEY_PULSE_AUTOREPEAT_EN
                    rep_cnt_next     = '0;
`endif
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            HELD: begin
                if (ks_reg) begin
                    state_next  = RELEASE_CHK;
                    db_cnt_next = '0;
                end else begin
`ifdef KEY_PULSE_AUTOREPEAT_EN
                    // Long initial delay, then a shorter steady cadence.
                    if (!repeat_active_reg && rep_cnt_reg == REP_DELAY_LAST) begin
                        press_pulse_next   = 1'b1;
                        rep_cnt_next       = '0;
                        repeat_active_next = 1'b1;
                    end else if (repeat_active_reg && rep_cnt_reg == REP_PERIOD_LAST) begin
                        press_pulse_next = 1'b1;
                        rep_cnt_next     = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + REP_W'(1);
                    end
`endif
                end
            end
            RELEASE_CHK: begin
                // rep_cnt stays frozen here so a rejected release only delays the cadence.
                if (!ks_reg) begin
                    state_next = HELD;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next         = IDLE;
                    release_pulse_next = 1'b1;
`ifdef KEY_PULSE_AUTOREPEAT_EN
                    repeat_active_next = 1'b0;
`endif
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pressed       = (state_reg == HELD) || (state_reg == RELEASE_CHK);
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
`ifdef KEY_PULSE_AUTOREPEAT_EN
    assign repeat_active = repeat_active_reg;
`else
    assign repeat_active = 1'b0;
`endif

endmodule
